// File: rtl/qr_acc_pkg.sv
// Types and sizing helpers shared by the accelerator's load/unload datapath blocks.
// Pure declarations: no logic and no state.
package qr_acc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } unloader_state_t;

  function automatic int elems_per_beat(input int out_width, input int elem_width);
    return out_width / elem_width;
  endfunction

  // Ceiling division, so a short tail of elements still gets its own beat.
  function automatic int num_beats(input int num_elems, input int out_width, input int elem_width);
    int epb;
    epb = elems_per_beat(out_width, elem_width);
    return (num_elems + epb - 1) / epb;
  endfunction

endpackage

// File: rtl/beat_selector.sv
// Combinational staging-to-beat mux: picks beat beat_i out of the staged vector, zero-padding lanes
// past the last element; output forced to 0 when en_i is low. Zero latency, no flow control.
module beat_selector
  import qr_acc_pkg::*;
#(
  parameter int outputWidth  = 256,
  parameter int addrWidth    = 8,
  parameter int elementWidth = 8,
  parameter int numElements  = 128
) (
  input  logic [numElements-1:0][elementWidth-1:0] staging_i,
  input  logic [addrWidth-1:0]                     beat_i,
  input  logic                                     en_i,
  output logic [outputWidth-1:0]                   beat_o
);

  localparam int NB   = num_beats(numElements, outputWidth, elementWidth);
  localparam int PADW = NB * outputWidth;

  // Element 0 sits at the LSBs of the flattened vector, so zero-extending it to a whole number of
  // beats both packs lanes LSB-first and pads the partial final beat with zeros.
  logic [PADW-1:0] padded;
  assign padded = PADW'(staging_i);

  always_comb begin
    beat_o = '0;
    if (en_i && (int'(beat_i) < NB)) begin
      beat_o = padded[int'(beat_i) * outputWidth +: outputWidth];
    end
  end

endmodule

// File: rtl/feature_unloader.sv
// Snapshots a parallel result vector on capture_i and streams it out as indexed beats over valid/ready;
// beat 0 appears the cycle after capture, beats hold under backpressure, captures while draining are dropped.
module feature_unloader
  import qr_acc_pkg::*;
#(
  parameter int outputWidth  = 256,
  parameter int addrWidth    = 8,
  parameter int elementWidth = 8,
  parameter int numElements  = 128
) (
  input  logic                                     clk,
  input  logic                                     nrst,
  input  logic [numElements-1:0][elementWidth-1:0] data_i,
  input  logic                                     capture_i,
  output logic                                     busy_o,
  output logic                                     overrun_o,
  output logic [outputWidth-1:0]                   data_o,
  output logic [addrWidth-1:0]                     addr_o,
  output logic                                     valid_o,
  input  logic                                     ready_i,
  output logic                                     last_o
);

  localparam int NB = num_beats(numElements, outputWidth, elementWidth);
  localparam logic [addrWidth-1:0] LAST_BEAT = addrWidth'(NB - 1);

  if (outputWidth % elementWidth != 0) begin : g_bad_width
    $error("feature_unloader: outputWidth must be a multiple of elementWidth");
  end
  if (64'(NB) > (64'd1 << addrWidth)) begin : g_bad_addr
    $error("feature_unloader: addrWidth too narrow for the beat count");
  end

  unloader_state_t                          state_q, state_d;
  logic [addrWidth-1:0]                     cnt_q, cnt_d;
  logic [numElements-1:0][elementWidth-1:0] staging_q, staging_d;
  logic                                     overrun_q, overrun_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    staging_d = staging_q;
    overrun_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (capture_i) begin
          state_d   = DRAIN;
          cnt_d     = '0;
          staging_d = data_i;
        end
      end
      DRAIN: begin
        // A capture is dropped even on the final-handshake cycle: the snapshot is still owned until then.
        overrun_d = capture_i;
        if (ready_i) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      staging_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      staging_q <= staging_d;
      overrun_q <= overrun_d;
    end
  end

  assign valid_o   = (state_q == DRAIN);
  assign busy_o    = (state_q == DRAIN);
  assign addr_o    = cnt_q;
  assign last_o    = valid_o && (cnt_q == LAST_BEAT);
  assign overrun_o = overrun_q;

  beat_selector #(
    .outputWidth (outputWidth),
    .addrWidth   (addrWidth),
    .elementWidth(elementWidth),
    .numElements (numElements)
  ) u_beat_selector (
    .staging_i(staging_q),
    .beat_i   (cnt_q),
    .en_i     (valid_o),
    .beat_o   (data_o)
  );

endmodule

// File: tb/tb_feature_unloader.sv
// Scoreboarded bench: a default 128-element unloader and a 40-element (partial final beat) unloader.
// A queue-based model predicts beats from captured element lists; a negedge monitor pops and compares.
module tb_feature_unloader;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic [127:0][7:0] d0;
  logic [39:0][7:0]  d1;
  logic              cap0, cap1, rdy0, rdy1;
  logic              busy0, ovr0, v0, l0, busy1, ovr1, v1, l1;
  logic [255:0]      q0, q1;
  logic [7:0]        a0, a1;

  feature_unloader dut0 (
    .clk(clk), .nrst(nrst), .data_i(d0), .capture_i(cap0), .busy_o(busy0), .overrun_o(ovr0),
    .data_o(q0), .addr_o(a0), .valid_o(v0), .ready_i(rdy0), .last_o(l0)
  );

  feature_unloader #(.numElements(40)) dut1 (
    .clk(clk), .nrst(nrst), .data_i(d1), .capture_i(cap1), .busy_o(busy1), .overrun_o(ovr1),
    .data_o(q1), .addr_o(a1), .valid_o(v1), .ready_i(rdy1), .last_o(l1)
  );

  typedef struct packed {
    logic [255:0] data;
    logic [7:0]   addr;
    logic         last;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  int   n_chk = 0;
  int   n_pass = 0;
  bit   m_busy[2];
  int   m_left[2];
  bit   m_ovr[2];
  int   exp_hs[2];
  int   act_hs[2];
  bit   held[2];
  exp_t hold_v[2];
  logic [7:0] e0[$];
  logic [7:0] e1[$];

  task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Beat k carries elements k*32 .. k*32+31, element 0 in the low byte; absent elements read as 0.
  function automatic logic [255:0] exp_beat(input logic [7:0] e[$], input int k);
    logic [255:0] b;
    b = '0;
    for (int j = 0; j < 32; j++) begin
      if (k * 32 + j < e.size()) b[j*8 +: 8] = e[k*32 + j];
    end
    return b;
  endfunction

  task automatic model_step(input int u, input logic cap, input logic rdy, input logic [7:0] e[$]);
    exp_t x;
    int   nb;
    m_ovr[u] = m_busy[u] && cap;
    if (!m_busy[u]) begin
      if (cap) begin
        nb = (e.size() + 31) / 32;
        for (int k = 0; k < nb; k++) begin
          x.data = exp_beat(e, k);
          x.addr = 8'(k);
          x.last = (k == nb - 1);
          if (u == 0) sb0.push_back(x);
          else sb1.push_back(x);
        end
        m_busy[u] = 1'b1;
        m_left[u] = nb;
      end
    end else if (rdy) begin
      exp_hs[u]++;
      m_left[u]--;
      if (m_left[u] == 0) m_busy[u] = 1'b0;
    end
  endtask

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int u = 0; u < 2; u++) begin
        m_busy[u] = 1'b0;
        m_left[u] = 0;
        m_ovr[u]  = 1'b0;
      end
      sb0.delete();
      sb1.delete();
    end else begin
      e0 = {};
      for (int i = 0; i < 128; i++) e0.push_back(d0[i]);
      e1 = {};
      for (int i = 0; i < 40; i++) e1.push_back(d1[i]);
      model_step(0, cap0, rdy0, e0);
      model_step(1, cap1, rdy1, e1);
    end
  end

  task automatic mon(input int u, input logic v, input logic b, input logic ov, input logic [255:0] dat,
                     input logic [7:0] ad, input logic ls, input logic rdy);
    exp_t cur, x;
    cur.data = dat;
    cur.addr = ad;
    cur.last = ls;
    chk($sformatf("valid_u%0d", u), v, m_busy[u]);
    chk($sformatf("busy_u%0d", u), b, m_busy[u]);
    chk($sformatf("overrun_u%0d", u), ov, m_ovr[u]);
    if (!v) begin
      held[u] = 1'b0;
      chk($sformatf("idle_data_u%0d", u), {dat, ls}, '0);
      return;
    end
    if (held[u]) chk($sformatf("hold_stable_u%0d", u), cur, hold_v[u]);
    if (rdy) begin
      held[u] = 1'b0;
      act_hs[u]++;
      if ((u == 0 && sb0.size() == 0) || (u == 1 && sb1.size() == 0)) begin
        n_chk++;
        $display("FAIL unexpected_beat_u%0d: got addr %0d expected no beat", u, ad);
      end else begin
        x = (u == 0) ? sb0.pop_front() : sb1.pop_front();
        chk($sformatf("beat_data_u%0d_b%0d", u, x.addr), dat, x.data);
        chk($sformatf("beat_addr_u%0d", u), ad, x.addr);
        chk($sformatf("beat_last_u%0d_b%0d", u, x.addr), ls, x.last);
      end
    end else begin
      held[u]   = 1'b1;
      hold_v[u] = cur;
    end
  endtask

  always @(negedge clk) begin
    if (!nrst) begin
      held[0] = 1'b0;
      held[1] = 1'b0;
    end else begin
      mon(0, v0, busy0, ovr0, q0, a0, l0, rdy0);
      mon(1, v1, busy1, ovr1, q1, a1, l1, rdy1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    cap0 = 1'b0;
    cap1 = 1'b0;
    rdy0 = 1'b1;
    rdy1 = 1'b1;
    for (int i = 0; i < 200 && (m_busy[0] || m_busy[1]); i++) tick();
    chk("drain_timeout", m_busy[0] | m_busy[1], 1'b0);
  endtask

  bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  int h0;

  initial begin
    cap0 = 1'b0; cap1 = 1'b0; rdy0 = 1'b0; rdy1 = 1'b0; d0 = '0; d1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl_u0", {v0, busy0, l0, ovr0}, 4'b0);
    chk("rst_data_u0", q0, '0);
    chk("rst_addr_u0", a0, '0);
    chk("rst_ctrl_u1", {v1, busy1, l1, ovr1}, 4'b0);
    chk("rst_data_u1", q1, '0);
    chk("rst_addr_u1", a1, '0);
    @(posedge clk);
    #1 nrst = 1'b1;
    repeat (10) tick();

    // Full drain with ready held high: four consecutive beats then idle.
    for (int i = 0; i < 128; i++) d0[i] = 8'(i);
    h0 = act_hs[0];
    cap0 = 1'b1; rdy0 = 1'b1;
    tick();
    cap0 = 1'b0;
    repeat (4) tick();
    chk("full_drain_busy_after", busy0, 1'b0);
    chk("full_drain_handshakes", act_hs[0] - h0, 4);

    // Backpressure pattern.
    for (int i = 0; i < 128; i++) d0[i] = 8'($urandom);
    h0 = act_hs[0];
    cap0 = 1'b1;
    tick();
    cap0 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rdy0 = pat[i];
      tick();
    end
    chk("bp_busy_after", busy0, 1'b0);
    chk("bp_handshakes", act_hs[0] - h0, 4);

    // Overrun during beat 1, then a capture right after the final handshake.
    for (int i = 0; i < 128; i++) d0[i] = 8'(i);
    rdy0 = 1'b1; cap0 = 1'b1;
    tick();
    cap0 = 1'b0;
    tick();
    for (int i = 0; i < 128; i++) d0[i] = 8'(255 - i);
    cap0 = 1'b1;
    tick();
    cap0 = 1'b0;
    tick();
    tick();
    cap0 = 1'b1;
    tick();
    cap0 = 1'b0;
    chk("capture_after_final_accepted", busy0, 1'b1);
    wait_idle();

    // Capture exactly on the final-handshake cycle is dropped.
    cap0 = 1'b1;
    tick();
    cap0 = 1'b0;
    repeat (3) tick();
    cap0 = 1'b1;
    tick();
    cap0 = 1'b0;
    tick();
    chk("capture_on_final_dropped", busy0, 1'b0);

    // Partial final beat: 40 elements -> 2 beats.
    for (int i = 0; i < 40; i++) d1[i] = 8'(i + 100);
    h0 = act_hs[1];
    cap1 = 1'b1; rdy1 = 1'b1;
    tick();
    cap1 = 1'b0;
    tick();
    tick();
    chk("partial_busy_after", busy1, 1'b0);
    chk("partial_handshakes", act_hs[1] - h0, 2);

    // Randomized traffic on both units.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 128; i++) d0[i] = 8'($urandom);
      for (int i = 0; i < 40; i++) d1[i] = 8'($urandom);
      cap0 = ($urandom_range(0, 5) == 0);
      cap1 = ($urandom_range(0, 4) == 0);
      rdy0 = ($urandom_range(0, 3) != 0);
      rdy1 = ($urandom_range(0, 2) != 0);
      tick();
    end
    wait_idle();

    // Reset in the middle of a stalled beat 2.
    for (int i = 0; i < 128; i++) d0[i] = 8'($urandom);
    cap0 = 1'b1;
    tick();
    cap0 = 1'b0;
    tick();
    tick();
    rdy0 = 1'b0;
    tick();
    tick();
    chk("stalled_beat_index", a0, 8'd2);
    #2 nrst = 1'b0;
    #1;
    chk("rst_mid_valid", v0, 1'b0);
    chk("rst_mid_busy", busy0, 1'b0);
    chk("rst_mid_staging", |dut0.staging_q, 1'b0);
    tick();
    tick();
    nrst = 1'b1;
    tick();
    for (int i = 0; i < 128; i++) d0[i] = 8'($urandom);
    cap0 = 1'b1; rdy0 = 1'b1;
    tick();
    cap0 = 1'b0;
    wait_idle();
    tick();

    chk("sb0_empty", sb0.size(), 0);
    chk("sb1_empty", sb1.size(), 0);
    chk("hs_total_u0", act_hs[0], exp_hs[0]);
    chk("hs_total_u1", act_hs[1], exp_hs[1]);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
